// File: rtl/step_pulse_shaper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_pulse_shaper: turns DDA step strobes into timing-legal STEP/DIR pins |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module step_pulse_shaper #(
  parameter int PULSE_HIGH = 16,
  parameter int PULSE_LOW  = 16,
  parameter int DIR_SETUP  = 8,
  parameter int DIR_HOLD   = 8,
  parameter int FIFO_BITS  = 3
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 step_req,
  input  logic                 dir_req,
  input  logic                 enable,
  input  logic                 clear_overflow,
  output logic                 step_out,
  output logic                 dir_out,
  output logic                 busy,
  output logic [FIFO_BITS:0]   pending,
  output logic                 overflow,
  output logic signed [31:0]   position
);

  localparam int c_LOW_T  = (PULSE_LOW > DIR_HOLD) ? PULSE_LOW : DIR_HOLD;
  localparam int c_MAX_A  = (PULSE_HIGH > c_LOW_T) ? PULSE_HIGH : c_LOW_T;
  localparam int c_MAX    = (c_MAX_A > DIR_SETUP) ? c_MAX_A : DIR_SETUP;
  localparam int c_CW     = $clog2(c_MAX) + 1;
  localparam int c_DEPTH  = 1 << FIFO_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_CW-1:0]       r_cnt;
  logic [c_DEPTH-1:0]    r_mem;
  logic [FIFO_BITS-1:0]  r_wr;
  logic [FIFO_BITS-1:0]  r_rd;
  logic [FIFO_BITS:0]    r_count;
  logic                  r_step;
  logic                  r_dir;
  logic                  r_busy;
  logic                  r_overflow;
  logic signed [31:0]    r_position;

  logic                  w_full;
  logic                  w_decide;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_head;
  logic [FIFO_BITS:0]    w_count_nxt;
  logic signed [31:0]    w_delta;

  // IDLE and the final LOW cycle share the pop decision so back-to-back steps lose no cycle.
  assign w_full      = (r_count == (FIFO_BITS+1)'(c_DEPTH));
  assign w_decide    = (r_state == S_IDLE) || ((r_state == S_LOW) && (r_cnt == '0));
  assign w_pop       = w_decide && enable && (r_count != '0);
  assign w_push      = step_req && (!w_full || w_pop);
  assign w_drop      = step_req && w_full && !w_pop;
  assign w_head      = r_mem[r_rd];
  assign w_count_nxt = r_count + (FIFO_BITS+1)'(w_push) - (FIFO_BITS+1)'(w_pop);
  assign w_delta     = r_dir ? 32'sd1 : -32'sd1;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_mem      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= dir_req;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= w_count_nxt;
      if (clear_overflow) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_busy <= !(w_decide && !w_pop) || (w_count_nxt != '0);
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_step     <= 1'b0;
      r_dir      <= 1'b0;
      r_position <= '0;
    end else if (w_pop) begin
      if (w_head == r_dir) begin
        r_step     <= 1'b1;
        r_position <= r_position + w_delta;
        r_cnt      <= c_CW'(PULSE_HIGH - 1);
        r_state    <= S_HIGH;
      end else begin
        r_dir   <= w_head;
        r_cnt   <= c_CW'(DIR_SETUP - 1);
        r_state <= S_SETUP;
      end
    end else begin
      case (r_state)
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_step     <= 1'b1;
            r_position <= r_position + w_delta;
            r_cnt      <= c_CW'(PULSE_HIGH - 1);
            r_state    <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HIGH: begin
          if (r_cnt == '0) begin
            r_step  <= 1'b0;
            r_cnt   <= c_CW'(c_LOW_T - 1);
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign step_out = r_step;
  assign dir_out  = r_dir;
  assign busy     = r_busy;
  assign pending  = r_count;
  assign overflow = r_overflow;
  assign position = r_position;

endmodule
`default_nettype wire
